alu_op_arbiter: RTL

- Shares one external combinational ALU operator among NUM_REQ requesters.
- Each requester offers an operand pair plus opcode over a valid/ready handshake. The block grants one requester per cycle, round-robin, and drives the chosen operands to the operator.
- The operator result is captured in a one-entry response register, tagged with the requester id.
- Sits between the issue ports and the shared ALU datapath, upstream of accumulation cells.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/rr_pick.sv | 65 ++++++
 rtl/alu_op_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU operator arbiter.
//               - default operand and opcode widths
//               - opcode encodings for the shared operator
//               - clog2 helper used to size requester ids
// Config      : none (ALU_ARB_FIXED_PRIO_EN is consumed by rr_pick)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 3;

  // Opcode encodings. The arbiter passes these through unchanged; they are
  // listed here so requesters and the operator agree on one table.
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Ceiling log2, clamped to at least 1 so a 1-bit id is always legal.
  function automatic int alu_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating priority encoder. Returns the first
//               asserted bit of valid found when scanning upward from ptr
//               with wrap-around modulo NUM_REQ.
// Ports       : valid     in  NUM_REQ  request vector
//               ptr       in  ID_W     scan start index (0..NUM_REQ-1)
//               gnt       out ID_W     selected index (0 when none valid)
//               any_valid out 1        at least one request is valid
// Config      : ALU_ARB_FIXED_PRIO_EN - lowest index always wins, ptr ignored
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt,
  output logic               any_valid
);

  assign any_valid = |valid;

`ifdef ALU_ARB_FIXED_PRIO_EN

  // Start index is fixed at 0, so ptr carries no information here.
  logic ptr_unused;
  assign ptr_unused = ^ptr;

  always_comb begin
    gnt = '0;
    // Descending scan: the last hit written is the lowest index.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (valid[j]) gnt = ID_W'(j);
    end
  end

`else

  // Each valid index is scored by its rotational distance from ptr; the
  // smallest distance wins. Only constant bit-selects of valid are used.
  int best;
  int off;

  always_comb begin
    gnt  = '0;
    best = NUM_REQ;
    off  = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (valid[j]) begin
        off = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + NUM_REQ - int'(ptr));
        if (off < best) begin
          best = off;
          gnt  = ID_W'(j);
        end
      end
    end
  end

`endif

endmodule
`default_nettype wire

// File: rtl/alu_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_arbiter
// Description : Shares one combinational ALU operator among NUM_REQ
//               requesters. One request is granted per cycle (round-robin),
//               its operands are driven to the operator, and the result is
//               captured in a one-entry response register tagged with the
//               requester id.
// Ports       : i_clk        in  1               clock, rising edge
//               i_rst_n      in  1               async active-low reset
//               i_req_valid  in  NUM_REQ         request valid per requester
//               i_req_a      in  NUM_REQ*DATA_W  operand A, packed by index
//               i_req_b      in  NUM_REQ*DATA_W  operand B, packed by index
//               i_req_op     in  NUM_REQ*OP_W    opcode, packed by index
//               o_req_ready  out NUM_REQ         one-hot grant or zero
//               o_op_a       out DATA_W          operand A to operator
//               o_op_b       out DATA_W          operand B to operator
//               o_op_sel     out OP_W            opcode to operator
//               i_op_result  in  DATA_W          operator result, same cycle
//               o_rsp_valid  out 1               response register full
//               o_rsp_data   out DATA_W          registered result
//               o_rsp_id     out ID_W            producing requester index
//               i_rsp_ready  in  1               downstream accepts response
// Config      : ALU_ARB_FIXED_PRIO_EN - fixed priority (index 0 highest),
//               the round-robin pointer register is removed.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int ID_W    = alu_clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_b,
  input  logic [NUM_REQ*OP_W-1:0]   i_req_op,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]         o_op_a,
  output logic [DATA_W-1:0]         o_op_b,
  output logic [OP_W-1:0]           o_op_sel,
  input  logic [DATA_W-1:0]         i_op_result,
  output logic                      o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic [ID_W-1:0]           o_rsp_id,
  input  logic                      i_rsp_ready
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] sel;
  logic            any_valid;
  logic            can_issue;
  logic            fire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid     (i_req_valid),
    .ptr       (ptr),
    .gnt       (gnt),
    .any_valid (any_valid)
  );

  // The slot may be refilled in the same cycle it drains, giving one
  // result per cycle with no bubbles.
  assign can_issue = !o_rsp_valid || i_rsp_ready;

  // gnt always points at a valid requester when any_valid is set, so this is
  // exactly ready[gnt] && valid[gnt]. Reset gates it so no handshake can
  // complete while the response register is being cleared.
  assign fire = i_rst_n && can_issue && any_valid;

  always_comb begin
    o_req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (fire && (ID_W'(k) == gnt)) o_req_ready[k] = 1'b1;
    end
  end

  // With no request pending the operator still sees a defined operand set
  // (the pointer's requester), so its inputs never float or go X.
  assign sel = any_valid ? gnt : ptr;

  always_comb begin
    o_op_a   = i_req_a[0 +: DATA_W];
    o_op_b   = i_req_b[0 +: DATA_W];
    o_op_sel = i_req_op[0 +: OP_W];
    for (int k = 1; k < NUM_REQ; k++) begin
      if (ID_W'(k) == sel) begin
        o_op_a   = i_req_a[k*DATA_W +: DATA_W];
        o_op_b   = i_req_b[k*DATA_W +: DATA_W];
        o_op_sel = i_req_op[k*OP_W +: OP_W];
      end
    end
  end

  // Response register. Data and id hold across a drain so downstream can
  // still inspect the last result after o_rsp_valid falls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_id    <= '0;
    end else if (fire) begin
      o_rsp_valid <= 1'b1;
      o_rsp_data  <= i_op_result;
      o_rsp_id    <= gnt;
    end else if (i_rsp_ready) begin
      o_rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN

  assign ptr = '0;

`else

  // Pointer moves just past the winner, and only on an accepted request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    end
  end

`endif

endmodule
`default_nettype wire
